arctic_sequencer: RTL

//  Sequences the grid of node_arctic cells through an Arctic Circle (domino shuffling) run.

---
 rtl/arctic_pkg.sv | 29 ++
 rtl/arctic_if.sv | 33 +++
 rtl/arctic_lfsr.sv | 38 +++
 rtl/arctic_sequencer.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/arctic_pkg.sv
// Shared types and defaults for the Arctic Circle sequencer and node grid.
package arctic_pkg;

  localparam int unsigned DEF_RND_W  = 16;
  localparam int unsigned DEF_LFSR_W = 16;
  localparam int unsigned DEF_SETTLE = 4;
  localparam int unsigned DEF_ORD_W  = 4;

  // Default Galois feedback mask (x^16 + x^14 + x^13 + x^11 + 1).
  localparam logic [15:0] DEF_TAPS = 16'hB400;

  // Sequencer FSM states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_LATCH  = 3'd3,
    ST_FIN    = 3'd4
  } seq_state_e;

  // Node direction bit positions shared by node_arctic and the grid.
  typedef enum logic [1:0] {
    DIR_N = 2'd0,
    DIR_E = 2'd1,
    DIR_S = 2'd2,
    DIR_W = 2'd3
  } dir_e;

endpackage

// File: rtl/arctic_if.sv
// Control/status bundle between the I/O wrapper (master) and the sequencer (slave).
interface arctic_if
  import arctic_pkg::*;
#(
  parameter int unsigned RND_W  = DEF_RND_W,
  parameter int unsigned LFSR_W = DEF_LFSR_W,
  parameter int unsigned ORD_W  = DEF_ORD_W
);

  logic              start;
  logic              abort;
  logic              hold;
  logic [ORD_W-1:0]  order;
  logic              seed_ld;
  logic [LFSR_W-1:0] seed;
  logic [RND_W-1:0]  rnd_bus;
  logic              grid_clr;
  logic              grid_we;
  logic              busy;
  logic              done;
  logic [ORD_W-1:0]  iter;

  modport master (
    output start, abort, hold, order, seed_ld, seed,
    input  rnd_bus, grid_clr, grid_we, busy, done, iter
  );

  modport slave (
    input  start, abort, hold, order, seed_ld, seed,
    output rnd_bus, grid_clr, grid_we, busy, done, iter
  );

endinterface

// File: rtl/arctic_lfsr.sv
// Galois LFSR with synchronous load, step enable and a zero-lock guard on load.
module arctic_lfsr #(
  parameter int unsigned       LFSR_W = 16,
  parameter logic [LFSR_W-1:0] TAPS   = 16'hB400
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] q
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  // Load wins over step; an all-zero seed would lock the register, so it becomes 1.
  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = (seed == '0) ? LFSR_W'(1) : seed;
    end else if (step) begin
      lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
    end
  end

  // LFSR register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_W'(1);
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q = lfsr_q;

endmodule

// File: rtl/arctic_sequencer.sv
// Steps the node_arctic grid through an Arctic Circle run: clear, then per
// iteration settle with stable random bits, latch, and advance the LFSR.
module arctic_sequencer
  import arctic_pkg::*;
#(
  parameter int unsigned       RND_W  = DEF_RND_W,
  parameter int unsigned       LFSR_W = DEF_LFSR_W,
  parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(DEF_TAPS),
  parameter int unsigned       SETTLE = DEF_SETTLE,
  parameter int unsigned       ORD_W  = DEF_ORD_W
)(
  input logic     clk,
  input logic     rst_n,
  arctic_if.slave bus
);

  // Counter only ever holds SETTLE-1 down to 0.
  localparam int unsigned      CNT_W      = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE - 1);

  seq_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ORD_W-1:0]  iter_q, iter_d;
  logic [ORD_W-1:0]  order_q, order_d;
  logic [ORD_W-1:0]  iter_inc;
  logic              grid_clr_q, grid_clr_d;
  logic              grid_we_q, grid_we_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              lfsr_ld_c;
  logic              lfsr_step_c;
  logic [LFSR_W-1:0] lfsr_q;

  assign iter_inc = iter_q + ORD_W'(1);

  arctic_lfsr #(
    .LFSR_W (LFSR_W),
    .TAPS   (TAPS)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfsr_ld_c),
    .step  (lfsr_step_c),
    .seed  (bus.seed),
    .q     (lfsr_q)
  );

  // Next-state, counters and registered-output decode; abort overrides everything.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    iter_d      = iter_q;
    order_d     = order_q;
    lfsr_ld_c   = 1'b0;
    lfsr_step_c = 1'b0;
    grid_clr_d  = 1'b0;
    grid_we_d   = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        lfsr_ld_c = bus.seed_ld;
        if (bus.start) begin
          order_d = bus.order;
          iter_d  = '0;
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        if (order_q == '0) begin
          state_d = ST_FIN;
        end else begin
          state_d = ST_SETTLE;
          cnt_d   = CNT_RELOAD;
        end
      end
      ST_SETTLE: begin
        if (!bus.hold) begin
          if (cnt_q == '0) begin
            state_d = ST_LATCH;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      ST_LATCH: begin
        lfsr_step_c = 1'b1;
        iter_d      = iter_inc;
        if (iter_inc == order_q) begin
          state_d = ST_FIN;
        end else begin
          state_d = ST_SETTLE;
          cnt_d   = CNT_RELOAD;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if ((state_q != ST_IDLE) && bus.abort) begin
      state_d     = ST_IDLE;
      cnt_d       = cnt_q;
      iter_d      = iter_q;
      lfsr_step_c = 1'b0;
    end

    grid_clr_d = (state_d == ST_CLEAR);
    grid_we_d  = (state_d == ST_LATCH);
    done_d     = (state_d == ST_FIN);
    busy_d     = (state_d != ST_IDLE);
  end

  // State, counters and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      iter_q     <= '0;
      order_q    <= '0;
      grid_clr_q <= 1'b0;
      grid_we_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      iter_q     <= iter_d;
      order_q    <= order_d;
      grid_clr_q <= grid_clr_d;
      grid_we_q  <= grid_we_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.rnd_bus  = lfsr_q[RND_W-1:0];
  assign bus.grid_clr = grid_clr_q;
  assign bus.grid_we  = grid_we_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.iter     = iter_q;

endmodule
